// File: rtl/gray_pkg.sv
// Shared definitions for the gray-embedding packer and the read-side thresholder.
// Holds the luminance coefficients, component widths and the positions of the
// embedded gray bits inside the two SDRAM words.
package gray_pkg;

  localparam int COMP_W     = 10;
  localparam int GRAY_W     = 8;
  localparam int WORD_W     = 16;

  localparam int COEF_R     = 77;
  localparam int COEF_G     = 150;
  localparam int COEF_B     = 29;
  localparam int GRAY_SHIFT = 10;

  // 77*1023 and 29*1023 fit in 17 bits; 150*1023 = 153450 needs 18.
  localparam int PROD_RB_W  = 17;
  localparam int PROD_G_W   = 18;
  localparam int SUM_W      = 18;

  // Gray bit placement: word1 carries gray[7] at bit 15 and gray[6:5] at 1:0;
  // word2 carries gray[4] at 15, gray[3:2] at 11:10 and gray[1:0] at 1:0.
  localparam int W1_G7      = 15;
  localparam int W1_G65_LO  = 0;
  localparam int W2_G4      = 15;
  localparam int W2_G32_LO  = 10;
  localparam int W2_G10_LO  = 0;

  typedef enum logic {
    EMBED_OFF = 1'b0,
    EMBED_ON  = 1'b1
  } embed_e;

  // Per-pixel sideband that rides alongside the arithmetic pipeline.
  typedef struct packed {
    logic   sof;
    logic   last;
    logic   over;
    embed_e mode;
  } pix_tag_t;

  // Recover gray from a pair of embedded words (used by the read side).
  function automatic logic [GRAY_W-1:0] unpack_gray(input logic [WORD_W-1:0] w1,
                                                    input logic [WORD_W-1:0] w2);
    return {w1[W1_G7], w1[W1_G65_LO +: 2], w2[W2_G4], w2[W2_G32_LO +: 2],
            w2[W2_G10_LO +: 2]};
  endfunction

endpackage

// File: rtl/rgb_to_gray.sv
// Two-stage luminance pipeline: stage 1 registers the weighted products,
// stage 2 registers the shifted sum. RGB and a generic sideband are delayed
// alongside so the caller sees them aligned with the gray result.
module rgb_to_gray
  import gray_pkg::*;
#(
  parameter int SIDE_W = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [COMP_W-1:0] r_i,
  input  logic [COMP_W-1:0] g_i,
  input  logic [COMP_W-1:0] b_i,
  input  logic [SIDE_W-1:0] side_i,
  output logic              valid_o,
  output logic [GRAY_W-1:0] gray_o,
  output logic [COMP_W-1:0] r_o,
  output logic [COMP_W-1:0] g_o,
  output logic [COMP_W-1:0] b_o,
  output logic [SIDE_W-1:0] side_o
);

  logic                 valid1_q, valid2_q;
  logic [PROD_RB_W-1:0] prod_r_q, prod_b_q;
  logic [PROD_G_W-1:0]  prod_g_q;
  logic [GRAY_W-1:0]    gray_q;
  logic [COMP_W-1:0]    r1_q, g1_q, b1_q, r2_q, g2_q, b2_q;
  logic [SIDE_W-1:0]    side1_q, side2_q;

  // Valid bits are the only reset state; in-flight pixels vanish on reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      valid1_q <= valid_i;
      valid2_q <= valid1_q;
    end
  end

  // Datapath: products then truncated sum; only the bits above the shift survive.
  always_ff @(posedge clk_i) begin
    prod_r_q <= PROD_RB_W'(COEF_R) * PROD_RB_W'(r_i);
    prod_g_q <= PROD_G_W'(COEF_G) * PROD_G_W'(g_i);
    prod_b_q <= PROD_RB_W'(COEF_B) * PROD_RB_W'(b_i);
    r1_q     <= r_i;
    g1_q     <= g_i;
    b1_q     <= b_i;
    side1_q  <= side_i;
    gray_q   <= GRAY_W'((SUM_W'(prod_r_q) + prod_g_q + SUM_W'(prod_b_q)) >> GRAY_SHIFT);
    r2_q     <= r1_q;
    g2_q     <= g1_q;
    b2_q     <= b1_q;
    side2_q  <= side1_q;
  end

  assign valid_o = valid2_q;
  assign gray_o  = gray_q;
  assign r_o     = r2_q;
  assign g_o     = g2_q;
  assign b_o     = b2_q;
  assign side_o  = side2_q;

endmodule

// File: rtl/delay_gray_packer.sv
// Write-side packer: tags each pixel with frame position and embed mode,
// runs it through the luminance pipeline and packs RGB plus gray into the
// two SDRAM words three cycles after the pixel arrives.
module delay_gray_packer
  import gray_pkg::*;
#(
  parameter int FRAME_PIXELS = 307200
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iDVAL,
  input  logic              iSOF,
  input  logic [COMP_W-1:0] iR,
  input  logic [COMP_W-1:0] iG,
  input  logic [COMP_W-1:0] iB,
  input  logic              iEnable,
  output logic              oDVAL,
  output logic [WORD_W-1:0] oData1,
  output logic [WORD_W-1:0] oData2,
  output logic              oFrameDone,
  output logic              oOverrun
);

  localparam int              CNT_W    = $clog2(FRAME_PIXELS + 1);
  localparam logic [CNT_W-1:0] FrameCnt = CNT_W'(FRAME_PIXELS);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  embed_e            mode_q, mode_d;
  pix_tag_t          tag_in;
  pix_tag_t          tag_s2;
  logic [$bits(pix_tag_t)-1:0] tag_s2_raw;

  logic              valid_s2;
  logic [GRAY_W-1:0] gray_s2;
  logic [COMP_W-1:0] r_s2, g_s2, b_s2;
  logic [WORD_W-1:0] word1_d, word2_d;

  logic              dval_q, done_q, overrun_q;
  logic [WORD_W-1:0] data1_q, data2_q;

  // Frame position and mode for the incoming pixel; the counter saturates at a full frame.
  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    tag_in = '0;
    if (iDVAL) begin
      if (iSOF) begin
        cnt_d      = CNT_W'(1);
        mode_d     = embed_e'(iEnable);
        tag_in.sof = 1'b1;
      end else if (cnt_q < FrameCnt) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        tag_in.over = 1'b1;
      end
    end
    tag_in.last = iDVAL && !tag_in.over && (cnt_d == FrameCnt);
    tag_in.mode = mode_d;
  end

  // Counter and frame mode registers.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      cnt_q  <= '0;
      mode_q <= EMBED_OFF;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  rgb_to_gray #(
    .SIDE_W ($bits(pix_tag_t))
  ) u_rgb_to_gray (
    .clk_i   (iCLK),
    .rst_ni  (iRST_N),
    .valid_i (iDVAL),
    .r_i     (iR),
    .g_i     (iG),
    .b_i     (iB),
    .side_i  (tag_in),
    .valid_o (valid_s2),
    .gray_o  (gray_s2),
    .r_o     (r_s2),
    .g_o     (g_s2),
    .b_o     (b_s2),
    .side_o  (tag_s2_raw)
  );

  assign tag_s2 = tag_s2_raw;

  // Word packing: embedded gray takes the free MSB and the dropped component LSBs.
  always_comb begin
    word1_d = '0;
    word2_d = '0;
    if (tag_s2.mode == EMBED_ON) begin
      word1_d[W1_G7]           = gray_s2[7];
      word1_d[14:10]           = g_s2[9:5];
      word1_d[9:2]             = b_s2[9:2];
      word1_d[W1_G65_LO +: 2]  = gray_s2[6:5];
      word2_d[W2_G4]           = gray_s2[4];
      word2_d[14:12]           = g_s2[4:2];
      word2_d[W2_G32_LO +: 2]  = gray_s2[3:2];
      word2_d[9:2]             = r_s2[9:2];
      word2_d[W2_G10_LO +: 2]  = gray_s2[1:0];
    end else begin
      word1_d = {1'b0, g_s2[9:5], b_s2};
      word2_d = {1'b0, g_s2[4:0], r_s2};
    end
  end

  // Output stage: words, frame-done pulse and sticky overrun all land with oDVAL.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      dval_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      data1_q   <= '0;
      data2_q   <= '0;
    end else begin
      dval_q <= valid_s2;
      done_q <= valid_s2 && tag_s2.last;
      if (valid_s2) begin
        data1_q <= word1_d;
        data2_q <= word2_d;
        if (tag_s2.sof) begin
          overrun_q <= 1'b0;
        end else if (tag_s2.over) begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign oDVAL      = dval_q;
  assign oData1     = data1_q;
  assign oData2     = data2_q;
  assign oFrameDone = done_q;
  assign oOverrun   = overrun_q;

endmodule

// File: tb/tb_delay_gray_packer.sv
// Scoreboard bench for delay_gray_packer with a 16-pixel frame.
module tb_delay_gray_packer;

  localparam int FP = 16;

  logic        clk = 1'b0;
  logic        iRST_N;
  logic        iDVAL;
  logic        iSOF;
  logic [9:0]  iR, iG, iB;
  logic        iEnable;
  logic        oDVAL;
  logic [15:0] oData1, oData2;
  logic        oFrameDone;
  logic        oOverrun;

  typedef struct {
    logic [15:0] d1;
    logic [15:0] d2;
    logic        done;
    logic        ovr;
    logic        embed;
    logic [7:0]  gray;
    int          due;
  } exp_t;

  exp_t sbq[$];
  exp_t monE;

  int   checks;
  int   errors;
  int   cyc;
  int   doneSeen;

  int   mCnt;
  logic mMode;
  logic mOvr;

  delay_gray_packer #(
    .FRAME_PIXELS (FP)
  ) dut (
    .iCLK       (clk),
    .iRST_N     (iRST_N),
    .iDVAL      (iDVAL),
    .iSOF       (iSOF),
    .iR         (iR),
    .iG         (iG),
    .iB         (iB),
    .iEnable    (iEnable),
    .oDVAL      (oDVAL),
    .oData1     (oData1),
    .oData2     (oData2),
    .oFrameDone (oFrameDone),
    .oOverrun   (oOverrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] refGray(input logic [9:0] pr, input logic [9:0] pg,
                                         input logic [9:0] pb);
    int s;
    s = 77 * int'(pr) + 150 * int'(pg) + 29 * int'(pb);
    return 8'(s >> 10);
  endfunction

  function automatic logic [31:0] packWords(input logic [9:0] pr, input logic [9:0] pg,
                                            input logic [9:0] pb, input logic [7:0] gy,
                                            input logic emb);
    logic [15:0] w1, w2;
    if (emb) begin
      w1 = {gy[7], pg[9:5], pb[9:2], gy[6:5]};
      w2 = {gy[4], pg[4:2], gy[3:2], pr[9:2], gy[1:0]};
    end else begin
      w1 = {1'b0, pg[9:5], pb};
      w2 = {1'b0, pg[4:0], pr};
    end
    return {w1, w2};
  endfunction

  // Scoreboard monitor: every output beat must match the oldest pending pixel on its due cycle.
  always @(negedge clk) begin
    if (oFrameDone) doneSeen++;
    if (oDVAL) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL spurious_dval cyc %0d got oDVAL=1 want 0", cyc);
      end else begin
        monE = sbq.pop_front();
        checks++;
        if (cyc != monE.due) begin
          errors++;
          $display("[TB] FAIL latency got cyc %0d want cyc %0d", cyc, monE.due);
        end
        checks++;
        if (oData1 !== monE.d1) begin
          errors++;
          $display("[TB] FAIL data1 cyc %0d got %h want %h", cyc, oData1, monE.d1);
        end
        checks++;
        if (oData2 !== monE.d2) begin
          errors++;
          $display("[TB] FAIL data2 cyc %0d got %h want %h", cyc, oData2, monE.d2);
        end
        checks++;
        if (oFrameDone !== monE.done) begin
          errors++;
          $display("[TB] FAIL frame_done cyc %0d got %b want %b", cyc, oFrameDone, monE.done);
        end
        checks++;
        if (oOverrun !== monE.ovr) begin
          errors++;
          $display("[TB] FAIL overrun cyc %0d got %b want %b", cyc, oOverrun, monE.ovr);
        end
        if (monE.embed) begin
          checks++;
          if ({oData1[15], oData1[1:0], oData2[15], oData2[11:10], oData2[1:0]} !== monE.gray) begin
            errors++;
            $display("[TB] FAIL gray_extract cyc %0d got %h want %h", cyc,
                     {oData1[15], oData1[1:0], oData2[15], oData2[11:10], oData2[1:0]}, monE.gray);
          end
        end
      end
    end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
      checks++; errors++;
      $display("[TB] FAIL missing_dval cyc %0d got oDVAL=0 want 1", cyc);
      monE = sbq.pop_front();
    end
  end

  task automatic modelReset();
    mCnt  = 0;
    mMode = 1'b0;
    mOvr  = 1'b0;
  endtask

  task automatic modelStep(input logic ps, input logic pe, output logic xdone,
                           output logic xovr, output logic xemb);
    logic ovf;
    ovf = 1'b0;
    if (ps) begin
      mCnt  = 1;
      mMode = pe;
      mOvr  = 1'b0;
    end else if (mCnt < FP) begin
      mCnt++;
    end else begin
      ovf  = 1'b1;
      mOvr = 1'b1;
    end
    xdone = !ovf && (mCnt == FP);
    xovr  = mOvr;
    xemb  = mMode;
  endtask

  task automatic applyStimulus(input logic [9:0] pr, input logic [9:0] pg, input logic [9:0] pb,
                               input logic ps, input logic pe, input logic [15:0] x1,
                               input logic [15:0] x2, input logic xdone, input logic xovr,
                               input logic xemb);
    exp_t ex;
    ex.d1    = x1;
    ex.d2    = x2;
    ex.done  = xdone;
    ex.ovr   = xovr;
    ex.embed = xemb;
    ex.gray  = refGray(pr, pg, pb);
    ex.due   = cyc + 3;
    sbq.push_back(ex);
    iDVAL   = 1'b1;
    iSOF    = ps;
    iEnable = pe;
    iR      = pr;
    iG      = pg;
    iB      = pb;
    @(posedge clk); #1;
    iDVAL = 1'b0;
    iSOF  = 1'b0;
  endtask

  task automatic drivePixel(input logic [9:0] pr, input logic [9:0] pg, input logic [9:0] pb,
                            input logic ps, input logic pe);
    logic xdone, xovr, xemb;
    logic [31:0] w;
    modelStep(ps, pe, xdone, xovr, xemb);
    w = packWords(pr, pg, pb, refGray(pr, pg, pb), xemb);
    applyStimulus(pr, pg, pb, ps, pe, w[31:16], w[15:0], xdone, xovr, xemb);
  endtask

  task automatic driveKnown(input logic [9:0] pr, input logic [9:0] pg, input logic [9:0] pb,
                            input logic ps, input logic pe, input logic [15:0] x1,
                            input logic [15:0] x2);
    logic xdone, xovr, xemb;
    modelStep(ps, pe, xdone, xovr, xemb);
    applyStimulus(pr, pg, pb, ps, pe, x1, x2, xdone, xovr, xemb);
  endtask

  task automatic driveRandom(input logic ps, input logic pe);
    drivePixel(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
               10'($urandom_range(0, 1023)), ps, pe);
  endtask

  task automatic idle(input int n);
    iDVAL = 1'b0;
    iSOF  = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout got %0d pending want 0", sbq.size());
      sbq.delete();
    end
    idle(2);
  endtask

  task automatic test_reset();
    iRST_N  = 1'b0;
    iDVAL   = 1'b0;
    iSOF    = 1'b0;
    iEnable = 1'b0;
    iR = '0; iG = '0; iB = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (oDVAL !== 1'b0) begin errors++; $display("[TB] FAIL rst_dval got %b want 0", oDVAL); end
    checks++;
    if (oData1 !== 16'h0) begin errors++; $display("[TB] FAIL rst_data1 got %h want 0000", oData1); end
    checks++;
    if (oData2 !== 16'h0) begin errors++; $display("[TB] FAIL rst_data2 got %h want 0000", oData2); end
    checks++;
    if (oFrameDone !== 1'b0) begin errors++; $display("[TB] FAIL rst_done got %b want 0", oFrameDone); end
    checks++;
    if (oOverrun !== 1'b0) begin errors++; $display("[TB] FAIL rst_overrun got %b want 0", oOverrun); end
    iRST_N = 1'b1;
    modelReset();
    idle(2);
  endtask

  task automatic test_known_values();
    driveKnown(10'd1023, 10'd1023, 10'd1023, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    driveKnown(10'd1023, 10'd0,    10'd0,    1'b0, 1'b1, 16'h0002, 16'h0FFC);
    driveKnown(10'd0,    10'd0,    10'd0,    1'b0, 1'b1, 16'h0000, 16'h0000);
    drain();
    driveKnown(10'd1023, 10'd1023, 10'd1023, 1'b1, 1'b0, 16'h7FFF, 16'h7FFF);
    driveKnown(10'd0,    10'd0,    10'd0,    1'b0, 1'b0, 16'h0000, 16'h0000);
    drain();
  endtask

  task automatic test_mode_latch();
    int d0;
    d0 = doneSeen;
    driveRandom(1'b1, 1'b1);
    for (int i = 2; i <= FP; i++) driveRandom(1'b0, (i < 8));
    drain();
    checks++;
    if (doneSeen - d0 != 1) begin
      errors++;
      $display("[TB] FAIL mode_latch_done_count got %0d want 1", doneSeen - d0);
    end
  endtask

  task automatic test_overrun();
    int d0;
    d0 = doneSeen;
    driveRandom(1'b1, 1'b0);
    for (int i = 2; i <= FP + 4; i++) driveRandom(1'b0, 1'b0);
    drain();
    checks++;
    if (oOverrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_sticky got %b want 1", oOverrun); end
    checks++;
    if (doneSeen - d0 != 1) begin
      errors++;
      $display("[TB] FAIL overrun_done_count got %0d want 1", doneSeen - d0);
    end
    driveRandom(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) driveRandom(1'b0, 1'b1);
    driveRandom(1'b1, 1'b1);
    driveRandom(1'b0, 1'b1);
    drain();
    checks++;
    if (oOverrun !== 1'b0) begin errors++; $display("[TB] FAIL overrun_clear got %b want 0", oOverrun); end
    checks++;
    if (doneSeen - d0 != 1) begin
      errors++;
      $display("[TB] FAIL aborted_frame_done got %0d want 1", doneSeen - d0);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = doneSeen;
    driveRandom(1'b1, 1'b1);
    for (int i = 2; i <= FP; i++) driveRandom(1'b0, 1'b1);
    driveRandom(1'b1, 1'b0);
    for (int i = 2; i <= FP; i++) driveRandom(1'b0, 1'b1);
    drain();
    checks++;
    if (doneSeen - d0 != 2) begin
      errors++;
      $display("[TB] FAIL b2b_done_count got %0d want 2", doneSeen - d0);
    end
  endtask

  task automatic test_random_stream();
    int d0;
    d0 = doneSeen;
    for (int f = 0; f < 3; f++) begin
      for (int i = 1; i <= FP; i++) begin
        driveRandom(i == 1, 1'b1);
        idle($urandom_range(0, 5));
      end
    end
    drain();
    checks++;
    if (doneSeen - d0 != 3) begin
      errors++;
      $display("[TB] FAIL random_done_count got %0d want 3", doneSeen - d0);
    end
  endtask

  task automatic test_reset_inflight();
    int d0;
    driveRandom(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) driveRandom(1'b0, 1'b1);
    drain();
    for (int i = 0; i < 2; i++) begin
      iDVAL = 1'b1; iSOF = 1'b0; iEnable = 1'b1;
      iR = 10'($urandom_range(0, 1023));
      iG = 10'($urandom_range(0, 1023));
      iB = 10'($urandom_range(0, 1023));
      @(posedge clk); #1;
    end
    iDVAL  = 1'b0;
    iRST_N = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (oDVAL !== 1'b0) begin errors++; $display("[TB] FAIL inflight_dval got %b want 0", oDVAL); end
    checks++;
    if (oData1 !== 16'h0) begin errors++; $display("[TB] FAIL inflight_data1 got %h want 0000", oData1); end
    checks++;
    if (oData2 !== 16'h0) begin errors++; $display("[TB] FAIL inflight_data2 got %h want 0000", oData2); end
    repeat (2) @(posedge clk);
    #1;
    iRST_N = 1'b1;
    modelReset();
    idle(4);
    d0 = doneSeen;
    for (int i = 1; i <= FP; i++) driveRandom(1'b0, 1'b1);
    drain();
    checks++;
    if (doneSeen - d0 != 1) begin
      errors++;
      $display("[TB] FAIL post_reset_done got %0d want 1", doneSeen - d0);
    end
    driveRandom(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) driveRandom(1'b0, 1'b0);
    drain();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    doneSeen = 0;
    test_reset();
    test_known_values();
    test_mode_latch();
    test_overrun();
    test_back_to_back();
    test_random_stream();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
